// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg: shared FSM state type and default bus widths for apb_req_arbiter
package apb_arb_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
endpackage

// File: rtl/apb_req_arbiter_if.sv
// apb_req_arbiter_if: requester handshake plus APB master-port bundle
interface apb_req_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W = apb_arb_pkg::ADDR_W,
  parameter int DATA_W = apb_arb_pkg::DATA_W
);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_wr;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ-1:0] resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic resp_err;
  logic psel;
  logic penable;
  logic pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic pready;
  logic [DATA_W-1:0] prdata;
  modport slave (
    input req_valid, req_wr, req_addr, req_wdata, pready, prdata,
    output req_ready, resp_valid, resp_rdata, resp_err, psel, penable, pwrite, paddr, pwdata
  );
  modport master (
    output req_valid, req_wr, req_addr, req_wdata, pready, prdata,
    input req_ready, resp_valid, resp_rdata, resp_err, psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_req_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting after last grant
module rr_arbiter #(
  parameter int N = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 1; i <= N; i++) begin
      int k;
      k = (int'(last) + i) % N;
      if (!any && req[k]) begin
        any = 1'b1;
        gnt[k] = 1'b1;
        idx = IW'(k);
      end
    end
  end
endmodule

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin requester arbiter driving one APB SETUP/ACCESS sequence
// Optional ACCESS-phase timeout enabled by defining APB_TIMEOUT_EN.
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W = apb_arb_pkg::ADDR_W,
  parameter int DATA_W = apb_arb_pkg::DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic clk,
  input logic rst,
  apb_req_arbiter_if.slave bus
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad
    $error("apb_req_arbiter: parameter out of range");
  end
  apb_state_e state_q, state_d;
  logic [IW-1:0] last_q, last_d, gidx;
  logic [NUM_REQ-1:0] gnt, resp_valid_q, resp_valid_d;
  logic any, accept, done, tmo;
  logic psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d, resp_rdata_q, resp_rdata_d;
  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .req(bus.req_valid), .last(last_q), .gnt(gnt), .idx(gidx), .any(any)
  );
`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic resp_err_q, resp_err_d;
  assign tmo = state_q == ACCESS && !bus.pready && cnt_q == CW'(TIMEOUT_CYCLES - 1);
  always_comb begin
    cnt_d = state_q == ACCESS ? cnt_q + 1'b1 : '0;
    resp_err_d = done ? 1'b0 : tmo ? 1'b1 : resp_err_q;
  end
  always_ff @(posedge clk) begin
    cnt_q <= rst ? '0 : cnt_d;
    resp_err_q <= rst ? 1'b0 : resp_err_d;
  end
  assign bus.resp_err = resp_err_q;
`else
  assign tmo = 1'b0;
  assign bus.resp_err = 1'b0;
`endif
  always_comb begin
    accept = state_q == IDLE && any;
    done = state_q == ACCESS && bus.pready;
    state_d = accept ? SETUP : state_q == SETUP ? ACCESS : (done || tmo) ? IDLE : state_q;
    last_d = accept ? gidx : last_q;
    pwrite_d = accept ? bus.req_wr[gidx] : pwrite_q;
    paddr_d = accept ? bus.req_addr[int'(gidx)*ADDR_W +: ADDR_W] : paddr_q;
    pwdata_d = accept ? bus.req_wdata[int'(gidx)*DATA_W +: DATA_W] : pwdata_q;
    psel_d = state_d != IDLE;
    penable_d = state_d == ACCESS;
    resp_valid_d = (done || tmo) ? NUM_REQ'(1) << last_q : '0;
    resp_rdata_d = done ? (pwrite_q ? '0 : bus.prdata) : tmo ? '0 : resp_rdata_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q <= IW'(NUM_REQ - 1);
      psel_q <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q <= 1'b0;
      paddr_q <= '0;
      pwdata_q <= '0;
      resp_valid_q <= '0;
      resp_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      psel_q <= psel_d;
      penable_q <= penable_d;
      pwrite_q <= pwrite_d;
      paddr_q <= paddr_d;
      pwdata_q <= pwdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end
  assign bus.req_ready = state_q == IDLE ? gnt : '0;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.psel = psel_q;
  assign bus.penable = penable_q;
  assign bus.pwrite = pwrite_q;
  assign bus.paddr = paddr_q;
  assign bus.pwdata = pwdata_q;
endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: directed vectors for apb_req_arbiter with hand-computed expectations
module tb_apb_req_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_run = 0;
  int n_fail = 0;
  apb_req_arbiter_if #(.NUM_REQ(2), .ADDR_W(12), .DATA_W(32)) bus ();
  apb_req_arbiter #(.NUM_REQ(2), .ADDR_W(12), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.req_valid = '0;
    bus.req_wr = '0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.pready = 1'b1;
    bus.prdata = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_psel", bus.psel, 0);
    chk("rst_penable", bus.penable, 0);
    chk("rst_paddr", bus.paddr, 0);
    chk("rst_pwdata", bus.pwdata, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_rdata", bus.resp_rdata, 0);
    chk("rst_resp_err", bus.resp_err, 0);
    // single zero-wait write from requester 0
    bus.req_valid = 2'b01;
    bus.req_wr = 2'b01;
    bus.req_addr[11:0] = 12'h104;
    bus.req_wdata[31:0] = 32'hA5A5_0001;
    #1;
    chk("wr_ready", bus.req_ready, 2'b01);
    tick();
    bus.req_valid = '0;
    #1;
    chk("wr_setup_psel", {bus.psel, bus.penable}, 2'b10);
    chk("wr_setup_ready", bus.req_ready, 0);
    chk("wr_setup_pwrite", bus.pwrite, 1);
    chk("wr_setup_pwdata", bus.pwdata, 32'hA5A5_0001);
    tick();
    chk("wr_access", {bus.psel, bus.penable}, 2'b11);
    chk("wr_access_paddr", bus.paddr, 12'h104);
    tick();
    chk("wr_resp_valid", bus.resp_valid, 2'b01);
    chk("wr_resp_err", bus.resp_err, 0);
    chk("wr_resp_rdata", bus.resp_rdata, 0);
    chk("wr_idle_psel", bus.psel, 0);
    // read from requester 1 with three wait states
    tick();
    chk("rd_pre_resp", bus.resp_valid, 0);
    bus.pready = 1'b0;
    bus.prdata = 32'hDEAD_BEEF;
    bus.req_valid = 2'b10;
    bus.req_wr = 2'b00;
    bus.req_addr[23:12] = 12'h208;
    #1;
    chk("rd_ready", bus.req_ready, 2'b10);
    tick();
    bus.req_valid = '0;
    chk("rd_setup", {bus.psel, bus.penable}, 2'b10);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rd_access%0d", i), {bus.psel, bus.penable}, 2'b11);
      chk($sformatf("rd_paddr%0d", i), bus.paddr, 12'h208);
      chk($sformatf("rd_noresp%0d", i), bus.resp_valid, 0);
      if (i == 3) bus.pready = 1'b1;
    end
    tick();
    chk("rd_resp_valid", bus.resp_valid, 2'b10);
    chk("rd_resp_rdata", bus.resp_rdata, 32'hDEAD_BEEF);
    chk("rd_idle", {bus.psel, bus.penable}, 2'b00);
    // contention from reset: grants alternate 0,1,0,1
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req_valid = 2'b11;
    bus.req_wr = 2'b11;
    #1;
    chk("cont_ready0", bus.req_ready, 2'b01);
    for (int t = 0; t < 4; t++) begin
      tick();
      tick();
      tick();
      chk($sformatf("cont_resp%0d", t), bus.resp_valid, (t % 2) ? 2'b10 : 2'b01);
      chk($sformatf("cont_ready%0d", t + 1), bus.req_ready, (t % 2) ? 2'b01 : 2'b10);
    end
    // reset while the fifth transfer is in ACCESS
    tick();
    bus.req_valid = '0;
    tick();
    chk("rst_mid_access", {bus.psel, bus.penable}, 2'b11);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_mid_bus", {bus.psel, bus.penable}, 2'b00);
    chk("rst_mid_noresp", bus.resp_valid, 0);
    tick();
    chk("rst_mid_noresp2", bus.resp_valid, 0);
    bus.req_valid = 2'b11;
    bus.req_addr = {12'h0AA, 12'h0BB};
    #1;
    chk("rst_mid_regrant", bus.req_ready, 2'b01);
    // back-to-back: requester 0 re-requests in its response cycle
    tick();
    bus.req_valid = '0;
    tick();
    tick();
    bus.req_valid = 2'b01;
    bus.req_addr[11:0] = 12'h030;
    #1;
    chk("b2b_resp", bus.resp_valid, 2'b01);
    chk("b2b_ready", bus.req_ready, 2'b01);
    tick();
    bus.req_valid = '0;
    bus.pready = 1'b0;
    chk("b2b_setup", {bus.psel, bus.penable}, 2'b10);
    chk("b2b_paddr", bus.paddr, 12'h030);
`ifdef APB_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("tmo_access%0d", i), {bus.psel, bus.penable}, 2'b11);
    end
    tick();
    chk("tmo_resp_valid", bus.resp_valid, 2'b01);
    chk("tmo_resp_err", bus.resp_err, 1);
    chk("tmo_resp_rdata", bus.resp_rdata, 0);
    chk("tmo_psel", bus.psel, 0);
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("wait_access%0d", i), {bus.psel, bus.penable, bus.resp_valid}, 4'b1100);
    end
    bus.pready = 1'b1;
    tick();
    chk("wait_resp_valid", bus.resp_valid, 2'b01);
    chk("wait_resp_err", bus.resp_err, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
Round-robin arbiter and APB phase sequencer that shares the single APB interconnect path between NUM_REQ requesters (e.g. core LSU, debug module, DMA).
- Accepts one request at a time and drives the APB SETUP/ACCESS sequence toward the interconnect master port, which then decodes psel1..psel6.
- Returns read data, or write completion, to the winning requester.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_W, 12, APB address width
DATA_W, 32, APB data width
TIMEOUT_CYCLES, 16, ACCESS-phase wait limit (used only with APB_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
req_valid  in  NUM_REQ  per-requester request pending
req_wr  in  NUM_REQ  1=write, 0=read
req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  packed write data
req_ready  out  NUM_REQ  one-hot accept pulse
resp_valid  out  NUM_REQ  one-hot completion pulse
resp_rdata  out  DATA_W  read data, valid with resp_valid
resp_err  out  1  timeout error flag, valid with resp_valid
psel  out  1  APB select to interconnect
penable  out  1  APB enable
pwrite  out  1  APB write
paddr  out  ADDR_W  APB address
pwdata  out  DATA_W  APB write data
pready  in  1  APB ready from interconnect
prdata  in  DATA_W  APB read data

Behaviour:
- Reset values: state IDLE; psel=0, penable=0, pwrite=0, paddr=0, pwdata=0; resp_valid=0, resp_rdata=0, resp_err=0; last_grant=NUM_REQ-1, so requester 0 wins first.
- FSM states:
  - IDLE -> SETUP when any req_valid is high.
  - SETUP -> ACCESS unconditionally.
  - ACCESS -> IDLE on pready=1; otherwise stay in ACCESS.
- Arbitration (IDLE only, combinational):
  - Search order is last_grant+1, last_grant+2, ... modulo NUM_REQ; the first requester with req_valid high wins.
  - req_ready[winner]=1 for that single IDLE cycle; all other req_ready bits stay 0.
  - On the same edge, latch the winner's wr/addr/wdata into paddr/pwrite/pwdata and load last_grant with the winner index.
- APB outputs are registered:
  - SETUP: psel=1, penable=0.
  - ACCESS: psel=1, penable=1.
  - paddr/pwrite/pwdata hold stable from SETUP through the final ACCESS cycle.
  - IDLE: psel=0, penable=0; paddr/pwdata keep their last values.
- Completion:
  - The edge that samples pready=1 in ACCESS registers prdata (reads) or 0 (writes) into resp_rdata.
  - resp_valid[granted]=1 for exactly one cycle, the following IDLE cycle.
  - A new request can be accepted in that same IDLE cycle.
- Timing:
  - Minimum transfer, from accept cycle to resp_valid cycle: 3 cycles.
  - Zero-wait throughput: one transfer per 3 cycles.
- Requester rules: hold req_valid and payload stable until req_ready is seen. Deasserting req_valid before grant simply withdraws the request.
- Simultaneous requests: strict round-robin; no requester waits more than NUM_REQ-1 grants.
- Reset mid-transfer: the FSM returns to IDLE on the next edge and psel/penable drop. The pending response is discarded with no resp_valid. last_grant reinitialises.
- Requesters with index >= NUM_REQ do not exist. No address decode is done here; out-of-range handling belongs to the interconnect.

Optional Feature:
APB_TIMEOUT_EN
- Defined:
  - A cycle counter runs in ACCESS, cleared on entry.
  - If TIMEOUT_CYCLES cycles pass without pready, the FSM forces ACCESS -> IDLE.
  - psel drops, and resp_valid[granted] pulses with resp_err=1 and resp_rdata=0.
  - A normal completion drives resp_err=0.
- Undefined: no counter; ACCESS waits indefinitely; resp_err is tied 0.

Decomposition:
- Shared package apb_arb_pkg holds:
  - the state enum typedef apb_state_e {IDLE, SETUP, ACCESS};
  - default localparams ADDR_W=12, DATA_W=32.
- One natural sub-module, rr_arbiter: request vector plus last_grant in, one-hot grant plus encoded index out, purely combinational. It is instantiated inside apb_req_arbiter.

Test Plan:
1. Single write: req0 wr=1 addr=0x104 wdata=0xA5A5_0001, pready tied 1 -> req_ready[0] in cycle 0, SETUP cycle 1, ACCESS cycle 2 with paddr=0x104, resp_valid[0] in cycle 3, resp_err=0.
2. Read with 3 wait states: req1 rd addr=0x208, pready low 3 ACCESS cycles, prdata=0xDEAD_BEEF -> psel/penable stay 1 for 4 ACCESS cycles, paddr stable, resp_valid[1] with resp_rdata=0xDEAD_BEEF.
3. Contention: req0 and req1 both held valid across 4 transfers from reset -> grant order 0,1,0,1; never two grants in a row to the same requester.
4. Reset in ACCESS: assert rst for 1 cycle while penable=1 -> psel=0/penable=0 next cycle, no resp_valid, next grant goes to req0.
5. With APB_TIMEOUT_EN and TIMEOUT_CYCLES=16, pready held 0 -> exit ACCESS after 16 cycles, resp_valid with resp_err=1, resp_rdata=0.
6. Back-to-back: req0 issues a new request in its resp_valid cycle -> req_ready[0] in that same cycle, psel high the next cycle.
